prime_seq_checker: RTL

PRIME_SEQ_CHECKER -- requirements
Module: prime_seq_checker

---
 rtl/prime_pkg.sv | 16 +
 rtl/seq_rem.sv | 66 ++++++
 rtl/prime_seq_checker.sv | 112 +++++++++++
 3 files changed

// File: rtl/prime_pkg.sv
// Shared FSM encoding and small-value constants for the sequential
// trial-division primality checker.
package prime_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_TEST  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int unsigned NUM_TWO   = 2;
   localparam int unsigned NUM_THREE = 3;

endpackage

// File: rtl/seq_rem.sv
// Restoring divider that yields only the remainder, one quotient bit per edge.
// The first iteration runs on the edge that samples m_start.
module seq_rem #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m_start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             m_done,
   output logic [WIDTH-1:0] rem
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] rem_reg, shift_reg, div_reg;
   logic [WIDTH-1:0] src_rem, src_div, rem_next;
   logic             src_bit;
   logic [WIDTH:0]   partial;
   logic [CW-1:0]    cnt_reg;
   logic             busy_reg, done_reg;

   // On the start edge the operands come straight from the ports.
   always_comb begin
      src_rem  = m_start ? '0 : rem_reg;
      src_bit  = m_start ? dividend[WIDTH-1] : shift_reg[WIDTH-1];
      src_div  = m_start ? divisor : div_reg;
      partial  = {src_rem, src_bit};
      rem_next = partial[WIDTH-1:0];
      if (partial >= {1'b0, src_div})
         rem_next = WIDTH'(partial - {1'b0, src_div});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_reg   <= '0;
         shift_reg <= '0;
         div_reg   <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (m_start) begin
            rem_reg   <= rem_next;
            shift_reg <= dividend << 1;
            div_reg   <= divisor;
            cnt_reg   <= CW'(WIDTH - 1);
            busy_reg  <= 1'b1;
         end else if (busy_reg) begin
            rem_reg   <= rem_next;
            shift_reg <= shift_reg << 1;
            cnt_reg   <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign m_done = done_reg;
   assign rem    = rem_reg;

endmodule

// File: rtl/prime_seq_checker.sv
// Primality test by trial division with odd divisors up to sqrt(N),
// each remainder computed by the sequential seq_rem divider.
module prime_seq_checker
   import prime_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] n_in,
   output logic             ready,
   output logic             done,
   output logic             is_prime,
   output logic [WIDTH-1:0] factor
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] n_reg, i_reg, i_next;
   logic [WIDTH-1:0] factor_reg, factor_next, rem;
   logic             prime_reg, prime_next, m_start, m_done;
   logic [2*WIDTH-1:0] i_wide, n_wide, i_sq;

   // Double-width square so the sqrt bound can never overflow.
   assign i_wide = {{WIDTH{1'b0}}, i_reg};
   assign n_wide = {{WIDTH{1'b0}}, n_reg};
   assign i_sq   = i_wide * i_wide;

   seq_rem #(.WIDTH(WIDTH)) u_rem (
      .clk      (clk),
      .rst_n    (rst_n),
      .m_start  (m_start),
      .dividend (n_reg),
      .divisor  (i_reg),
      .m_done   (m_done),
      .rem      (rem)
   );

   always_comb begin
      state_next  = state_reg;
      i_next      = i_reg;
      prime_next  = prime_reg;
      factor_next = factor_reg;
      m_start     = 1'b0;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_CHECK;
         ST_CHECK: begin
            state_next = ST_DONE;
            if (n_reg < WIDTH'(NUM_TWO)) begin
               prime_next  = 1'b0;
               factor_next = '0;
            end else if (n_reg <= WIDTH'(NUM_THREE)) begin
               prime_next  = 1'b1;
               factor_next = n_reg;
            end else if (!n_reg[0]) begin
               prime_next  = 1'b0;
               factor_next = WIDTH'(NUM_TWO);
            end else begin
               i_next     = WIDTH'(NUM_THREE);
               state_next = ST_TEST;
            end
         end
         ST_TEST: begin
            if (i_sq > n_wide) begin
               prime_next  = 1'b1;
               factor_next = n_reg;
               state_next  = ST_DONE;
            end else begin
               m_start    = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (m_done) begin
               if (rem == '0) begin
                  prime_next  = 1'b0;
                  factor_next = i_reg;
                  state_next  = ST_DONE;
               end else begin
                  i_next     = i_reg + WIDTH'(NUM_TWO);
                  state_next = ST_TEST;
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         n_reg      <= '0;
         i_reg      <= '0;
         prime_reg  <= 1'b0;
         factor_reg <= '0;
      end else begin
         state_reg  <= state_next;
         i_reg      <= i_next;
         prime_reg  <= prime_next;
         factor_reg <= factor_next;
         if (state_reg == ST_IDLE && start)
            n_reg <= n_in;
      end
   end

   assign ready    = (state_reg == ST_IDLE);
   assign done     = (state_reg == ST_DONE);
   assign is_prime = prime_reg;
   assign factor   = factor_reg;

endmodule
